// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the TP3 MIPS pipeline: opcode/funct encodings,
// default datapath widths, the NOP encoding and a small helper that tells
// the decoder which opcodes take a zero-extended immediate.
package mips_pkg;

    localparam int NB_DATA_DEF = 32;
    localparam int NB_REG_DEF  = 5;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Logical immediates are unsigned; everything else (including LUI,
    // whose shift happens in EX) is sign-extended.
    function automatic logic is_zero_ext(input logic [5:0] opcode);
        return (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
    endfunction

endpackage

// File: rtl/instruction_decode_if.sv
// instruction_decode_if
// Bundles the IF-side inputs, write-back port, debug port and ID/EX outputs
// of the decode stage.
//   master : the surrounding pipeline / bench (drives i_*, observes o_*)
//   slave  : the decode stage itself
interface instruction_decode_if #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5
);
    logic               i_stall;
    logic               i_halt;
    logic [NB_DATA-1:0] i_instruction;
    logic [NB_DATA-1:0] i_pc;
    logic               i_wb_write;
    logic [NB_REG-1:0]  i_wb_reg;
    logic [NB_DATA-1:0] i_wb_data;
    logic [NB_REG-1:0]  i_dbg_reg;

    logic [NB_DATA-1:0] o_dbg_data;
    logic               o_valid;
    logic [NB_DATA-1:0] o_pc;
    logic [NB_DATA-1:0] o_rs_data;
    logic [NB_DATA-1:0] o_rt_data;
    logic [NB_DATA-1:0] o_imm_ext;
    logic [NB_DATA-1:0] o_branch_target;
    logic [5:0]         o_opcode;
    logic [5:0]         o_funct;
    logic [4:0]         o_shamt;
    logic [NB_REG-1:0]  o_rs;
    logic [NB_REG-1:0]  o_rt;
    logic [NB_REG-1:0]  o_rd;

    modport master (
        output i_stall, i_halt, i_instruction, i_pc,
               i_wb_write, i_wb_reg, i_wb_data, i_dbg_reg,
        input  o_dbg_data, o_valid, o_pc, o_rs_data, o_rt_data, o_imm_ext,
               o_branch_target, o_opcode, o_funct, o_shamt, o_rs, o_rt, o_rd
    );

    modport slave (
        input  i_stall, i_halt, i_instruction, i_pc,
               i_wb_write, i_wb_reg, i_wb_data, i_dbg_reg,
        output o_dbg_data, o_valid, o_pc, o_rs_data, o_rt_data, o_imm_ext,
               o_branch_target, o_opcode, o_funct, o_shamt, o_rs, o_rt, o_rd
    );
endinterface

// File: rtl/instruction_decode_register_file.sv
// register_file
// 2^NB_REG x NB_DATA register file with r0 hardwired to zero.
// Ports:
//   i_clk, i_reset (async, active-low clear of every register)
//   i_wb_write/i_wb_reg/i_wb_data : single write port
//   i_rs/o_rs_data, i_rt/o_rt_data : read ports with write-through bypass
//   i_dbg/o_dbg_data               : raw read port, no bypass
module register_file #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_wb_write,
    input  logic [NB_REG-1:0]  i_wb_reg,
    input  logic [NB_DATA-1:0] i_wb_data,
    input  logic [NB_REG-1:0]  i_rs,
    input  logic [NB_REG-1:0]  i_rt,
    input  logic [NB_REG-1:0]  i_dbg,
    output logic [NB_DATA-1:0] o_rs_data,
    output logic [NB_DATA-1:0] o_rt_data,
    output logic [NB_DATA-1:0] o_dbg_data
);
    localparam int DEPTH = 2 ** NB_REG;

    logic [NB_DATA-1:0] regs_q [DEPTH];

    // r0 is a constant; every other entry is its own cleared register so the
    // whole file resets asynchronously.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
        if (gi == 0) begin : g_zero
            assign regs_q[gi] = '0;
        end else begin : g_store
            always_ff @(posedge i_clk or negedge i_reset) begin
                if (!i_reset) begin
                    regs_q[gi] <= '0;
                end else if (i_wb_write && (i_wb_reg == NB_REG'(gi))) begin
                    regs_q[gi] <= i_wb_data;
                end
            end
        end
    end

    // Write-through: a result being written this cycle is visible to the
    // instruction being decoded in the same cycle.
    logic rs_bypass;
    logic rt_bypass;
    assign rs_bypass = i_wb_write && (i_wb_reg == i_rs) && (i_rs != '0);
    assign rt_bypass = i_wb_write && (i_wb_reg == i_rt) && (i_rt != '0);

    assign o_rs_data  = rs_bypass ? i_wb_data : regs_q[i_rs];
    assign o_rt_data  = rt_bypass ? i_wb_data : regs_q[i_rt];
    assign o_dbg_data = regs_q[i_dbg];

endmodule

// File: rtl/instruction_decode.sv
// instruction_decode
// ID stage: field extraction, operand read (with bypass), immediate
// extension, branch-target adder and the ID/EX pipeline register.
// Ports:
//   i_clk   : clock, all state on rising edge
//   i_reset : asynchronous active-low reset (clears ID/EX and register file)
//   id_bus  : instruction_decode_if.slave (IF inputs, WB port, debug, ID/EX)
module instruction_decode
    import mips_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_REG  = NB_REG_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    instruction_decode_if.slave   id_bus
);
    typedef struct packed {
        logic               valid;
        logic [NB_DATA-1:0] pc;
        logic [NB_DATA-1:0] rs_data;
        logic [NB_DATA-1:0] rt_data;
        logic [NB_DATA-1:0] imm_ext;
        logic [NB_DATA-1:0] branch_target;
        logic [5:0]         opcode;
        logic [5:0]         funct;
        logic [4:0]         shamt;
        logic [NB_REG-1:0]  rs;
        logic [NB_REG-1:0]  rt;
        logic [NB_REG-1:0]  rd;
    } idex_t;

    logic [NB_DATA-1:0] instr;
    logic [5:0]         opcode;
    logic [NB_REG-1:0]  rs_idx;
    logic [NB_REG-1:0]  rt_idx;
    logic [NB_DATA-1:0] rs_data;
    logic [NB_DATA-1:0] rt_data;
    logic [NB_DATA-1:0] imm_ext;
    idex_t              decoded;
    idex_t              idex_d;
    idex_t              idex_q;

    assign instr  = id_bus.i_instruction;
    assign opcode = instr[31:26];
    assign rs_idx = instr[21 +: NB_REG];
    assign rt_idx = instr[16 +: NB_REG];

    register_file #(
        .NB_DATA (NB_DATA),
        .NB_REG  (NB_REG)
    ) u_register_file (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_wb_write (id_bus.i_wb_write),
        .i_wb_reg   (id_bus.i_wb_reg),
        .i_wb_data  (id_bus.i_wb_data),
        .i_rs       (rs_idx),
        .i_rt       (rt_idx),
        .i_dbg      (id_bus.i_dbg_reg),
        .o_rs_data  (rs_data),
        .o_rt_data  (rt_data),
        .o_dbg_data (id_bus.o_dbg_data)
    );

    assign imm_ext = is_zero_ext(opcode)
                   ? {{(NB_DATA-16){1'b0}},      instr[15:0]}
                   : {{(NB_DATA-16){instr[15]}}, instr[15:0]};

    always_comb begin
        decoded               = '0;
        decoded.valid         = 1'b1;
        decoded.pc            = id_bus.i_pc;
        decoded.rs_data       = rs_data;
        decoded.rt_data       = rt_data;
        decoded.imm_ext       = imm_ext;
        // Word offset: wraps modulo 2^NB_DATA.
        decoded.branch_target = id_bus.i_pc + {imm_ext[NB_DATA-3:0], 2'b00};
        decoded.opcode        = opcode;
        decoded.funct         = instr[5:0];
        decoded.shamt         = instr[10:6];
        decoded.rs            = rs_idx;
        decoded.rt            = rt_idx;
        decoded.rd            = instr[11 +: NB_REG];
    end

    // Halt outranks stall so a frozen pipeline never gains a bubble.
    always_comb begin
        idex_d = idex_q;
        if (!id_bus.i_halt) begin
            if (id_bus.i_stall) begin
                idex_d = '0;
            end else begin
                idex_d = decoded;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign id_bus.o_valid         = idex_q.valid;
    assign id_bus.o_pc            = idex_q.pc;
    assign id_bus.o_rs_data       = idex_q.rs_data;
    assign id_bus.o_rt_data       = idex_q.rt_data;
    assign id_bus.o_imm_ext       = idex_q.imm_ext;
    assign id_bus.o_branch_target = idex_q.branch_target;
    assign id_bus.o_opcode        = idex_q.opcode;
    assign id_bus.o_funct         = idex_q.funct;
    assign id_bus.o_shamt         = idex_q.shamt;
    assign id_bus.o_rs            = idex_q.rs;
    assign id_bus.o_rt            = idex_q.rt;
    assign id_bus.o_rd            = idex_q.rd;

endmodule

// File: tb/tb_instruction_decode.sv
// Randomised self-checking bench for instruction_decode against a
// behavioural model of the decode stage and register file.
module tb_instruction_decode;

    logic clk;
    logic rst_n;

    instruction_decode_if #(.NB_DATA(32), .NB_REG(5)) bus ();

    instruction_decode #(.NB_DATA(32), .NB_REG(5)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .id_bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] valid;
        logic [31:0] pc;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm_ext;
        logic [31:0] bt;
        logic [31:0] opcode;
        logic [31:0] funct;
        logic [31:0] shamt;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] rd;
    } exp_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mregs [32];
    exp_t        exp_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got %08h want %08h", tag, obs, want);
        end
    endtask

    function automatic exp_t zero_exp();
        exp_t e;
        e = '{default: 32'h0};
        return e;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".valid"},  {31'h0, bus.o_valid},   exp_q.valid);
        chk({tag, ".pc"},     bus.o_pc,               exp_q.pc);
        chk({tag, ".rs_data"},bus.o_rs_data,          exp_q.rs_data);
        chk({tag, ".rt_data"},bus.o_rt_data,          exp_q.rt_data);
        chk({tag, ".imm"},    bus.o_imm_ext,          exp_q.imm_ext);
        chk({tag, ".bt"},     bus.o_branch_target,    exp_q.bt);
        chk({tag, ".opcode"}, {26'h0, bus.o_opcode},  exp_q.opcode);
        chk({tag, ".funct"},  {26'h0, bus.o_funct},   exp_q.funct);
        chk({tag, ".shamt"},  {27'h0, bus.o_shamt},   exp_q.shamt);
        chk({tag, ".rs"},     {27'h0, bus.o_rs},      exp_q.rs);
        chk({tag, ".rt"},     {27'h0, bus.o_rt},      exp_q.rt);
        chk({tag, ".rd"},     {27'h0, bus.o_rd},      exp_q.rd);
        chk({tag, ".dbg"},    bus.o_dbg_data,         mregs[bus.i_dbg_reg]);
    endtask

    // One clock with the currently driven inputs; the model predicts the
    // ID/EX contents and register state from the MIPS decode rules.
    task automatic step(input string tag);
        logic [31:0] instr, pc, imm, ext;
        int unsigned op, rs, rt, wr;
        exp_t        e;
        instr = bus.i_instruction;
        pc    = bus.i_pc;
        op    = instr >> 26;
        rs    = (instr >> 21) % 32;
        rt    = (instr >> 16) % 32;
        imm   = instr % 32'h10000;
        if (op == 12 || op == 13 || op == 14) ext = imm;
        else if (imm >= 32'h8000)             ext = imm - 32'h10000;
        else                                  ext = imm;
        wr = bus.i_wb_reg;
        e.valid   = 1;
        e.pc      = pc;
        e.rs_data = (bus.i_wb_write && wr == rs && rs != 0) ? bus.i_wb_data : mregs[rs];
        e.rt_data = (bus.i_wb_write && wr == rt && rt != 0) ? bus.i_wb_data : mregs[rt];
        e.imm_ext = ext;
        e.bt      = pc + ext * 4;
        e.opcode  = op;
        e.funct   = instr % 64;
        e.shamt   = (instr >> 6) % 32;
        e.rs      = rs;
        e.rt      = rt;
        e.rd      = (instr >> 11) % 32;
        if (!bus.i_halt) begin
            if (bus.i_stall) exp_q = zero_exp();
            else             exp_q = e;
        end
        if (bus.i_wb_write && wr != 0) mregs[wr] = bus.i_wb_data;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        bus.i_stall       = 1'b0;
        bus.i_halt        = 1'b0;
        bus.i_instruction = 32'h0;
        bus.i_pc          = 32'h0;
        bus.i_wb_write    = 1'b0;
        bus.i_wb_reg      = 5'd0;
        bus.i_wb_data     = 32'h0;
        bus.i_dbg_reg     = 5'd0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        exp_q = zero_exp();
        rst_n = 1'b0;

        // Reset held with random activity on every input.
        for (int c = 0; c < 4; c++) begin
            bus.i_stall       = 1'($urandom);
            bus.i_halt        = 1'($urandom);
            bus.i_instruction = $urandom;
            bus.i_pc          = $urandom;
            bus.i_wb_write    = 1'b1;
            bus.i_wb_reg      = 5'($urandom_range(1, 31));
            bus.i_wb_data     = $urandom;
            bus.i_dbg_reg     = bus.i_wb_reg;
            @(posedge clk);
            #1;
            check_all("reset");
        end
        for (int r = 0; r < 32; r++) begin
            bus.i_dbg_reg = 5'(r);
            #1;
            chk("reset_dbg", bus.o_dbg_data, 32'h0);
        end
        idle_inputs();
        rst_n = 1'b1;

        // Write r5, then read it back through decode.
        bus.i_wb_write = 1'b1; bus.i_wb_reg = 5'd5; bus.i_wb_data = 32'hDEAD_BEEF;
        bus.i_dbg_reg = 5'd5;
        step("wr_r5");
        bus.i_wb_write = 1'b0;
        bus.i_instruction = 32'h00A6_3020; bus.i_pc = 32'h0000_0004;
        step("add_read");
        chk("add_rs_data", bus.o_rs_data, 32'hDEAD_BEEF);
        chk("add_rs", {27'h0, bus.o_rs}, 32'd5);
        chk("add_rd", {27'h0, bus.o_rd}, 32'd6);
        chk("add_funct", {26'h0, bus.o_funct}, 32'h20);

        // Same instruction with the write landing in the decode cycle.
        bus.i_wb_write = 1'b1; bus.i_wb_reg = 5'd5; bus.i_wb_data = 32'h1122_3344;
        step("add_bypass");
        chk("bypass_rs_data", bus.o_rs_data, 32'h1122_3344);

        // r0 ignores writes, with and without bypass opportunity.
        bus.i_wb_reg = 5'd0; bus.i_wb_data = 32'h0000_1234; bus.i_dbg_reg = 5'd0;
        bus.i_instruction = 32'h0000_0020;
        step("r0_write");
        bus.i_wb_write = 1'b0;
        step("r0_read");
        chk("r0_rs_data", bus.o_rs_data, 32'h0);

        // Immediate extension.
        bus.i_instruction = 32'h2008_FFFC;
        step("addi_ext");
        chk("addi_imm", bus.o_imm_ext, 32'hFFFF_FFFC);
        bus.i_instruction = 32'h3508_FFFC;
        step("ori_ext");
        chk("ori_imm", bus.o_imm_ext, 32'h0000_FFFC);

        // Branch target.
        bus.i_pc = 32'h0000_0010; bus.i_instruction = 32'h1000_FFFF;
        step("beq_neg");
        chk("beq_neg_bt", bus.o_branch_target, 32'h0000_000C);
        bus.i_instruction = 32'h1000_0003;
        step("beq_pos");
        chk("beq_pos_bt", bus.o_branch_target, 32'h0000_001C);

        // Two bubbles, then the held instruction is captured.
        bus.i_stall = 1'b1;
        step("stall1");
        step("stall2");
        chk("stall_valid", {31'h0, bus.o_valid}, 32'h0);
        bus.i_stall = 1'b0;
        bus.i_instruction = 32'h00A6_3020; bus.i_pc = 32'h0000_0020;
        step("post_stall");

        // Halt freezes ID/EX while write-back to r9 drains.
        bus.i_halt = 1'b1; bus.i_dbg_reg = 5'd9;
        for (int c = 0; c < 5; c++) begin
            bus.i_instruction = $urandom;
            bus.i_pc = $urandom;
            bus.i_wb_write = 1'b1; bus.i_wb_reg = 5'd9; bus.i_wb_data = $urandom;
            step("halt");
        end
        chk("halt_r9", bus.o_dbg_data, bus.i_wb_data);
        bus.i_wb_write = 1'b0;
        bus.i_stall = 1'b1;
        step("halt_stall1");
        step("halt_stall2");
        chk("halt_stall_valid", {31'h0, bus.o_valid}, 32'h1);
        idle_inputs();

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            logic [31:0] ins;
            ins = $urandom;
            if ($urandom_range(0, 3) == 0)
                ins[31:26] = 6'($urandom_range(12, 14));
            bus.i_instruction = ins;
            bus.i_pc          = $urandom;
            bus.i_stall       = ($urandom_range(0, 7) == 0);
            bus.i_halt        = ($urandom_range(0, 7) == 0);
            bus.i_wb_write    = 1'($urandom);
            bus.i_wb_reg      = ($urandom_range(0, 3) == 0) ? ins[25:21] : 5'($urandom);
            bus.i_wb_data     = $urandom;
            bus.i_dbg_reg     = 5'($urandom);
            step("rand");
        end

        // Asynchronous reset between edges, with a pending write to r10.
        idle_inputs();
        bus.i_wb_write = 1'b1; bus.i_wb_reg = 5'd10; bus.i_wb_data = 32'h5555_AAAA;
        bus.i_instruction = 32'h00A6_3020; bus.i_pc = 32'h40;
        step("pre_areset");
        bus.i_wb_data = 32'h0000_CAFE;
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        exp_q = zero_exp();
        bus.i_dbg_reg = 5'd10;
        check_all("areset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.i_wb_write = 1'b0;
        #1;
        chk("areset_r10", bus.o_dbg_data, 32'h0);
        step("post_areset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
